// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings, opcode
// constants, instruction classes, alu_ctrl and wb_sel encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_JAL,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Map a 7-bit opcode onto the supported instruction classes.
  function automatic instr_class_t classify(input logic [6:0] op);
    instr_class_t cls;
    case (op)
      OP_R:     cls = CLS_R;
      OP_I:     cls = CLS_I;
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      OP_BEQ:   cls = CLS_BEQ;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request handshake between the controller and the shared
// instruction/data memory.
// Handshake: mem_req is held high by the controller for as long as a request
// is outstanding; the request completes in the cycle where mem_ready is high
// while mem_req is high. mem_we qualifies the request as a store and is only
// meaningful while mem_req is high. mem_ready with mem_req low is ignored.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder: opcode/funct3/funct7 -> alu_ctrl.
// Loads, stores and JAL use ADD; BEQ uses SUB for the zero compare.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  instr_class_t cls;
  logic [3:0]   code;

  assign cls = classify(opcode);

  // Select the ALU operation; only R-type looks at funct7 (SUB vs ADD).
  always_comb begin
    code = ALU_ADD;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  code = (cls == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b111:  code = ALU_AND;
          3'b110:  code = ALU_OR;
          3'b100:  code = ALU_XOR;
          3'b010:  code = ALU_SLT;
          3'b001:  code = ALU_SLL;
          3'b101:  code = ALU_SRL;
          default: code = ALU_ADD;
        endcase
      end
      CLS_BEQ: code = ALU_SUB;
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and selects,
// handshakes with memory and counts retired instructions.
// Build option: CTRL_TRAP_EN -- an illegal opcode parks the FSM in TRAP until
// reset and raises illegal_instr; otherwise it is skipped as a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32,
  parameter int ALU_CTRL_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_ctrl_if.master       mem,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    zero,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    alu_src,
  output logic [ALU_CTRL_W-1:0]   alu_ctrl,
  output logic [1:0]              wb_sel,
  output logic                    reg_write,
  output logic                    instr_retired,
  output logic [RETIRE_CNT_W-1:0] retire_count,
  output logic                    illegal_instr,
  output logic [2:0]              state
);

  state_t                state_q, state_d;
  instr_class_t          cls;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
  logic                  mem_req_c, mem_we_c;

  assign cls   = classify(opcode);
  assign state = state_q;

  multicycle_ctrl_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu_ctrl)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes, decoded from the current state.
  always_comb begin
    state_d       = state_q;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src       = 1'b0;
    alu_ctrl      = '0;
    wb_sel        = WB_ALU;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
`ifdef CTRL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_ctrl = dec_alu_ctrl;
        case (cls)
          CLS_R: state_d = ST_WB;
          // The immediate is the second operand for I-ALU ops.
          CLS_I: begin
            alu_src = 1'b1;
            state_d = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          CLS_BEQ: begin
            pc_src        = 1'b1;
            pc_write      = zero;
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
          end
          CLS_JAL: begin
            pc_src        = 1'b1;
            pc_write      = 1'b1;
            reg_write     = 1'b1;
            wb_sel        = WB_PC4;
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cls == CLS_STORE);
        if (mem.mem_ready) begin
          if (cls == CLS_STORE) begin
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write     = 1'b1;
        wb_sel        = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;

  // Retired-instruction counter, wrapping modulo 2^RETIRE_CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             retire_count <= '0;
    else if (instr_retired) retire_count <= retire_count + RETIRE_CNT_W'(1);
  end

`ifdef CTRL_TRAP_EN
  // TRAP is terminal until reset, so this flag stays set once raised.
  assign illegal_instr = (state_q == ST_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Uses a 3-bit retire counter so
// counter wrap is reached. Honours CTRL_TRAP_EN for the illegal-opcode case.
module tb_multicycle_ctrl;

  localparam int CW = 3;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_BEQ   = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic          zero = 1'b0;
  logic          ir_write, pc_write, pc_src, alu_src, reg_write;
  logic          instr_retired, illegal_instr;
  logic [3:0]    alu_ctrl;
  logic [1:0]    wb_sel;
  logic [CW-1:0] retire_count;
  logic [2:0]    state;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.RETIRE_CNT_W(CW), .ALU_CTRL_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mif),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero          (zero),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_src       (alu_src),
    .alu_ctrl      (alu_ctrl),
    .wb_sel        (wb_sel),
    .reg_write     (reg_write),
    .instr_retired (instr_retired),
    .retire_count  (retire_count),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [17:0]   exp_q[$];
  logic [17:0]   obs_vec;
  logic [CW-1:0] exp_cnt;
  int            n_checks = 0;
  int            n_errors = 0;

  assign obs_vec = {state, mif.mem_req, mif.mem_we, ir_write, pc_write, pc_src,
                    alu_src, alu_ctrl, wb_sel, reg_write, instr_retired,
                    illegal_instr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic irw, input logic pcw, input logic pcs,
                                     input logic alus, input logic [3:0] alu,
                                     input logic [1:0] wb, input logic rw, input logic ret,
                                     input logic ill);
    return {st, req, we, irw, pcw, pcs, alus, alu, wb, rw, ret, ill};
  endfunction

  // Reference ALU operation for an instruction.
  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] r;
    r = 4'd0;
    if (op == T_R || op == T_I) begin
      case (f3)
        3'b000:  r = (op == T_R && f7[5]) ? 4'd1 : 4'd0;
        3'b111:  r = 4'd2;
        3'b110:  r = 4'd3;
        3'b100:  r = 4'd4;
        3'b010:  r = 4'd5;
        3'b001:  r = 4'd6;
        3'b101:  r = 4'd7;
        default: r = 4'd0;
      endcase
    end else if (op == T_BEQ) begin
      r = 4'd1;
    end
    return r;
  endfunction

  // Monitor: one expected control vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("ctrl_vec", 32'(obs_vec), 32'(exp_q.pop_front()));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mif.mem_ready = 1'b1;
    #1;
    check("reset_outputs", 32'(obs_vec), 32'd0);
    check("reset_count", 32'(retire_count), 32'd0);
    step();
    step();
    check("reset_hold", 32'(obs_vec), 32'd0);
    reset = 1'b1;
    exp_cnt = '0;
    exp_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
    step();
  endtask

  // Drive one instruction starting in FETCH; fw/mw are wait cycles in FETCH/MEM.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zb, input int fw, input int mw);
    logic [3:0] alu;
    logic       retired;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    zero   = zb;
    alu    = ref_alu(op, f3, f7);
    retired = 1'b1;
    for (int i = 0; i < fw; i++) begin
      mif.mem_ready = 1'b0;
      exp_q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
      step();
    end
    mif.mem_ready = 1'b1;
    exp_q.push_back(mk(3'd1, 1, 0, 1, 1, 0, 0, 4'd0, 2'd0, 0, 0, 0));
    step();
    mif.mem_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
    step();
    mif.mem_ready = 1'($urandom_range(0, 1));
    case (op)
      T_R, T_I: begin
        exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, (op == T_I), alu, 2'd0, 0, 0, 0));
        step();
        mif.mem_ready = 1'($urandom_range(0, 1));
        exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 1, 1, 0));
        step();
      end
      T_LOAD, T_STORE: begin
        exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 0, 0));
        step();
        for (int i = 0; i < mw; i++) begin
          mif.mem_ready = 1'b0;
          exp_q.push_back(mk(3'd4, 1, (op == T_STORE), 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
          step();
        end
        mif.mem_ready = 1'b1;
        if (op == T_STORE) begin
          exp_q.push_back(mk(3'd4, 1, 1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 1, 0));
          step();
        end else begin
          exp_q.push_back(mk(3'd4, 1, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
          step();
          mif.mem_ready = 1'($urandom_range(0, 1));
          exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 4'd0, 2'd1, 1, 1, 0));
          step();
        end
      end
      T_BEQ: begin
        exp_q.push_back(mk(3'd3, 0, 0, 0, zb, 1, 0, 4'd1, 2'd0, 0, 1, 0));
        step();
      end
      T_JAL: begin
        exp_q.push_back(mk(3'd3, 0, 0, 0, 1, 1, 0, 4'd0, 2'd2, 1, 1, 0));
        step();
      end
      default: begin
        retired = 1'b0;
`ifdef CTRL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 1));
          step();
          mif.mem_ready = 1'($urandom_range(0, 1));
        end
`endif
      end
    endcase
    if (retired) exp_cnt = exp_cnt + 1'b1;
    check("retire_count", 32'(retire_count), 32'(exp_cnt));
  endtask

  // Reset asserted while a store is in MEM: the write strobe must drop at once.
  task automatic abort_store();
    opcode = T_STORE;
    funct3 = 3'b010;
    funct7 = '0;
    mif.mem_ready = 1'b1;
    exp_q.push_back(mk(3'd1, 1, 0, 1, 1, 0, 0, 4'd0, 2'd0, 0, 0, 0));
    step();
    exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0));
    step();
    exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 0, 0));
    step();
    mif.mem_ready = 1'b0;
    #1;
    check("abort_pre_we", 32'(mif.mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_we", 32'(mif.mem_we), 32'd0);
    check("abort_count", 32'(retire_count), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [6:0] tbl_op[8] = '{T_R, T_R, T_I, T_LOAD, T_STORE, T_BEQ, T_JAL, T_I};
  logic [2:0] tbl_f3[8] = '{3'b000, 3'b110, 3'b101, 3'b010, 3'b010, 3'b000, 3'b000, 3'b111};
  logic [6:0] tbl_f7[8] = '{7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  initial begin
    mif.mem_ready = 1'b1;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    do_reset();
    // Directed: R-type ADD/SUB and remaining funct3 decodes.
    run_instr(T_R, 3'b000, 7'h00, 0, 0, 0);
    run_instr(T_R, 3'b000, 7'h20, 0, 0, 0);
    run_instr(T_R, 3'b111, 7'h00, 0, 0, 0);
    run_instr(T_R, 3'b100, 7'h00, 0, 0, 0);
    run_instr(T_R, 3'b010, 7'h00, 0, 0, 0);
    run_instr(T_R, 3'b001, 7'h00, 0, 0, 0);
    run_instr(T_R, 3'b011, 7'h00, 0, 0, 0);
    run_instr(T_I, 3'b000, 7'h20, 0, 0, 0);
    // Load with wait states in FETCH and MEM; store; branches; jal.
    run_instr(T_LOAD, 3'b010, 7'h00, 0, 3, 2);
    run_instr(T_STORE, 3'b010, 7'h00, 0, 1, 2);
    run_instr(T_BEQ, 3'b000, 7'h00, 1, 0, 0);
    run_instr(T_BEQ, 3'b000, 7'h00, 0, 0, 0);
    run_instr(T_JAL, 3'b000, 7'h00, 0, 0, 0);
    // Randomised mix with random wait states.
    for (int n = 0; n < 8; n++) begin
      int k;
      k = $urandom_range(0, 7);
      run_instr(tbl_op[k], tbl_f3[k], tbl_f7[k], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
    // Illegal opcode.
    run_instr(T_BAD, 3'b000, 7'h00, 0, 0, 0);
`ifdef CTRL_TRAP_EN
    check("trap_sticky", 32'(illegal_instr), 32'd1);
    do_reset();
    check("trap_cleared", 32'(illegal_instr), 32'd0);
    run_instr(T_R, 3'b000, 7'h00, 0, 0, 0);
`else
    check("illegal_flag", 32'(illegal_instr), 32'd0);
    run_instr(T_R, 3'b110, 7'h00, 0, 0, 0);
`endif
    abort_store();
    do_reset();
    run_instr(T_R, 3'b000, 7'h00, 0, 0, 0);
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
